msd_dimm_sched: RTL and testbench

- Synthesisable, clocked successor to the trace-driven DIMM queue model.
- Accepts CPU memory requests (read / write / instruction fetch) into a parametrised FIFO.
- Decodes each request into DDR5 channel / bank group / bank / row / column fields.
- Issues the two-cycle DDR5 command sequence (ACT0, ACT1, RD0/WR0, RD1/WR1, PRE) with programmable timing gaps, and sits between the trace-driven CPU front end and the DIMM command logger.

---
 rtl/msd_dimm_sched.sv | 238 +++++++++++++++++++++++
 tb/tb_msd_dimm_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/msd_dimm_sched.sv
// msd_dimm_sched: CPU request FIFO feeding a DDR5 ACT/CAS/PRE command scheduler.
// Optional MSD_OPEN_PAGE_EN selects an open-page policy with a per-bank row table.
module msd_dimm_sched #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 34,
    parameter int T_RCD  = 4,
    parameter int T_RTP  = 3,
    parameter int T_WR   = 6,
    parameter int T_RP   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_op,
    input  logic [ADDR_W-1:0]       req_addr,
    output logic                    cmd_valid,
    output logic [2:0]              cmd_code,
    output logic                    cmd_ch,
    output logic [2:0]              cmd_bg,
    output logic [1:0]              cmd_bank,
    output logic [ADDR_W-19:0]      cmd_row,
    output logic [5:0]              cmd_col,
    output logic [$clog2(DEPTH):0]  q_count,
    output logic                    q_full,
    output logic                    q_empty,
    output logic                    err_op
);
    localparam int PW    = $clog2(DEPTH);
    localparam int CNTW  = PW + 1;
    localparam int RW    = ADDR_W - 18;
    localparam int T_A   = (T_RCD > T_RTP) ? T_RCD : T_RTP;
    localparam int T_B   = (T_WR > T_RP) ? T_WR : T_RP;
    localparam int T_MAX = (T_A > T_B) ? T_A : T_B;
    localparam int CW    = $clog2(T_MAX) + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_ACT0, S_ACT1, S_W_RCD, S_CAS0, S_CAS1, S_W_PRE, S_PRE, S_W_RP
    } state_t;

    logic [ADDR_W+1:0]  r_mem [DEPTH];
    logic [PW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [CNTW-1:0]    r_count;
    logic               r_full, r_empty, r_ready, r_err;
    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [1:0]         r_work_op;
    logic [ADDR_W-1:0]  r_work_addr;
    logic               r_cmd_valid, r_cmd_ch;
    logic [2:0]         r_cmd_code, r_cmd_bg;
    logic [1:0]         r_cmd_bank;
    logic [RW-1:0]      r_cmd_row;
    logic [5:0]         r_cmd_col;

    state_t             w_state_nxt;
    logic [CW-1:0]      w_cnt_nxt;
    logic               w_push, w_pop;
    logic [CNTW-1:0]    w_count_nxt;
    logic [1:0]         w_op_nxt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic [RW-1:0]      w_row_out;
    logic [2:0]         w_code_nxt;
    logic               w_unused;

    function automatic logic [2:0] f_code(input state_t s, input logic wr);
        case (s)
            S_ACT0:  return 3'd1;
            S_ACT1:  return 3'd2;
            S_CAS0:  return wr ? 3'd5 : 3'd3;
            S_CAS1:  return wr ? 3'd6 : 3'd4;
            S_PRE:   return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    assign w_push      = req_valid && r_ready && (req_op != 2'd3);
    assign w_op_nxt    = w_pop ? r_mem[r_rd_ptr][ADDR_W+1:ADDR_W] : r_work_op;
    assign w_addr_nxt  = w_pop ? r_mem[r_rd_ptr][ADDR_W-1:0] : r_work_addr;
    assign w_code_nxt  = f_code(w_state_nxt, w_op_nxt == 2'd1);
    assign w_unused    = ^r_work_addr[5:0];

`ifdef MSD_OPEN_PAGE_EN
    logic           r_open [64];
    logic [RW-1:0]  r_trow [64];
    logic           r_chk;
    logic [5:0]     w_idx;
    logic           w_opened, w_hit;

    // {ch, bg, bank} occupy addr[11:6], so they index the bank table directly
    assign w_idx     = r_work_addr[11:6];
    assign w_opened  = r_open[w_idx];
    assign w_hit     = w_opened && (r_trow[w_idx] == r_work_addr[ADDR_W-1:18]);
    assign w_row_out = (w_state_nxt == S_PRE) ? r_trow[w_idx] : w_addr_nxt[ADDR_W-1:18];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk <= 1'b0;
            for (int i = 0; i < 64; i++) r_open[i] <= 1'b0;
        end else begin
            r_chk <= w_pop;
            if (r_state == S_ACT0) r_open[w_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_ACT0) r_trow[w_idx] <= r_work_addr[ADDR_W-1:18];
    end
`else
    assign w_row_out = w_addr_nxt[ADDR_W-1:18];
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
`ifdef MSD_OPEN_PAGE_EN
                // popped request is classified one cycle later against the bank table
                if (r_chk) w_state_nxt = w_hit ? S_CAS0 : (w_opened ? S_PRE : S_ACT0);
                else if (!r_empty) w_pop = 1'b1;
`else
                if (!r_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ACT0;
                end
`endif
            end
            S_ACT0: w_state_nxt = S_ACT1;
            S_ACT1: begin
                w_state_nxt = S_W_RCD;
                w_cnt_nxt   = CW'(T_RCD - 2);
            end
            S_W_RCD: begin
                if (r_cnt == '0) w_state_nxt = S_CAS0;
                else             w_cnt_nxt   = r_cnt - CW'(1);
            end
            S_CAS0: w_state_nxt = S_CAS1;
            S_CAS1: begin
`ifdef MSD_OPEN_PAGE_EN
                w_state_nxt = S_IDLE;
`else
                w_state_nxt = S_W_PRE;
                w_cnt_nxt   = (r_work_op == 2'd1) ? CW'(T_WR - 2) : CW'(T_RTP - 2);
`endif
            end
            S_W_PRE: begin
                if (r_cnt == '0) w_state_nxt = S_PRE;
                else             w_cnt_nxt   = r_cnt - CW'(1);
            end
            S_PRE: begin
                w_state_nxt = S_W_RP;
                w_cnt_nxt   = CW'(T_RP - 2);
            end
            S_W_RP: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end else begin
`ifdef MSD_OPEN_PAGE_EN
                    w_state_nxt = S_ACT0;
`else
                    // last recovery cycle may pop so ACT0 lands exactly T_RP after PRE
                    w_pop       = !r_empty;
                    w_state_nxt = r_empty ? S_IDLE : S_ACT0;
`endif
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)      w_count_nxt = r_count + CNTW'(1);
        else if (!w_push && w_pop) w_count_nxt = r_count - CNTW'(1);
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {req_op, req_addr};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_ready     <= 1'b1;
            r_err       <= 1'b0;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_work_op   <= '0;
            r_work_addr <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_code  <= '0;
            r_cmd_ch    <= 1'b0;
            r_cmd_bg    <= '0;
            r_cmd_bank  <= '0;
            r_cmd_row   <= '0;
            r_cmd_col   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count     <= w_count_nxt;
            r_full      <= (w_count_nxt == CNTW'(DEPTH));
            r_empty     <= (w_count_nxt == '0);
            r_ready     <= (w_count_nxt != CNTW'(DEPTH));
            r_err       <= req_valid && r_ready && (req_op == 2'd3);
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_work_op   <= w_op_nxt;
            r_work_addr <= w_addr_nxt;
            // command outputs are registered from the next state so they align with it
            r_cmd_code  <= w_code_nxt;
            r_cmd_valid <= (w_code_nxt != 3'd0);
            r_cmd_ch    <= w_addr_nxt[6];
            r_cmd_bg    <= w_addr_nxt[9:7];
            r_cmd_bank  <= w_addr_nxt[11:10];
            r_cmd_row   <= w_row_out;
            r_cmd_col   <= w_addr_nxt[17:12];
        end
    end

    assign req_ready = r_ready;
    assign cmd_valid = r_cmd_valid;
    assign cmd_code  = r_cmd_code;
    assign cmd_ch    = r_cmd_ch;
    assign cmd_bg    = r_cmd_bg;
    assign cmd_bank  = r_cmd_bank;
    assign cmd_row   = r_cmd_row;
    assign cmd_col   = r_cmd_col;
    assign q_count   = r_count;
    assign q_full    = r_full;
    assign q_empty   = r_empty;
    assign err_op    = r_err;

endmodule

// File: tb/tb_msd_dimm_sched.sv
// tb_msd_dimm_sched: cycle-exact bench for msd_dimm_sched (default closed-page build).
`timescale 1ns/1ps
module tb_msd_dimm_sched;
    localparam int DEPTH = 16, ADDR_W = 34, T_RCD = 4, T_RTP = 3, T_WR = 6, T_RP = 4;
    localparam int NCYC = 4096, NREQ = 1024;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                req_valid = 1'b0;
    logic [1:0]          req_op = '0;
    logic [ADDR_W-1:0]   req_addr = '0;
    logic                req_ready, cmd_valid, cmd_ch, q_full, q_empty, err_op;
    logic [2:0]          cmd_code, cmd_bg;
    logic [1:0]          cmd_bank;
    logic [ADDR_W-19:0]  cmd_row;
    logic [5:0]          cmd_col;
    logic [$clog2(DEPTH):0] q_count;

    always #5 clk = ~clk;

    msd_dimm_sched #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .T_RCD(T_RCD), .T_RTP(T_RTP),
                     .T_WR(T_WR), .T_RP(T_RP)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .cmd_ch(cmd_ch), .cmd_bg(cmd_bg), .cmd_bank(cmd_bank), .cmd_row(cmd_row),
        .cmd_col(cmd_col), .q_count(q_count), .q_full(q_full), .q_empty(q_empty),
        .err_op(err_op));

    typedef struct {
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
        int ch, bg, bank, row, col, cas;
    } vec_t;

    int n_chk = 0, n_fail = 0, t = 0;
    int exp_code [NCYC];
    logic [ADDR_W-1:0] exp_addr [NCYC];
    bit exp_err [NCYC];
    int acc_cyc [NREQ], act_cyc [NREQ];
    int n_req, last_pre, end_cyc;
    int max_cnt, err_pulses, obs_pre, obs_gap;
    int cap_ch, cap_bg, cap_bank, cap_row, cap_col, cap_code;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, t, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NCYC; i++) begin
            exp_code[i] = 0;
            exp_addr[i] = '0;
            exp_err[i]  = 1'b0;
        end
        n_req = 0; last_pre = -100; end_cyc = 0;
    endfunction

    // Each request's whole command timeline follows from its accept cycle and the previous PRE.
    task automatic model_accept(input logic [1:0] op, input logic [ADDR_W-1:0] addr, input int a);
        int act0, cas, pre;
        bit wr;
        if (op == 2'd3) begin
            exp_err[a+1] = 1'b1;
            if (a + 2 > end_cyc) end_cyc = a + 2;
            return;
        end
        wr   = (op == 2'd1);
        act0 = (a + 2 > last_pre + T_RP) ? a + 2 : last_pre + T_RP;
        cas  = act0 + 1 + T_RCD;
        pre  = cas + 1 + (wr ? T_WR : T_RTP);
        if (pre + T_RP >= NCYC || n_req >= NREQ) begin
            $display("FAIL model_capacity cycle %0d: got %0d expected below %0d", t, pre, NCYC);
            $fatal(1, "model capacity exceeded");
        end
        exp_code[act0] = 1; exp_code[act0+1] = 2;
        exp_code[cas] = wr ? 5 : 3; exp_code[cas+1] = wr ? 6 : 4; exp_code[pre] = 7;
        foreach (exp_addr[i]) if (i >= act0 && i <= pre) exp_addr[i] = addr;
        acc_cyc[n_req] = a; act_cyc[n_req] = act0; n_req++;
        last_pre = pre; end_cyc = pre + T_RP;
    endtask

    function automatic int model_count(input int c);
        int n = 0;
        for (int i = 0; i < n_req; i++) begin
            if (acc_cyc[i] < c) n++;
            if (act_cyc[i] <= c) n--;
        end
        return n;
    endfunction

    task automatic step(input bit v, input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                        output bit acc);
        int c, e;
        logic [ADDR_W-1:0] ea;
        c  = model_count(t);
        e  = exp_code[t];
        ea = exp_addr[t];
        chk("cmd_valid", cmd_valid, e != 0);
        chk("cmd_code", cmd_code, e);
        if (e != 0) begin
            chk("cmd_ch", cmd_ch, ea[6]);
            chk("cmd_bg", cmd_bg, ea[9:7]);
            chk("cmd_bank", cmd_bank, ea[11:10]);
            chk("cmd_row", cmd_row, ea[ADDR_W-1:18]);
            chk("cmd_col", cmd_col, ea[17:12]);
        end
        chk("q_count", q_count, c);
        chk("q_full", q_full, c == DEPTH);
        chk("q_empty", q_empty, c == 0);
        chk("req_ready", req_ready, c != DEPTH);
        chk("err_op", err_op, exp_err[t]);
        if (int'(q_count) > max_cnt) max_cnt = int'(q_count);
        if (err_op) err_pulses++;
        if (cmd_code == 3'd3 || cmd_code == 3'd5) begin
            cap_ch = cmd_ch; cap_bg = cmd_bg; cap_bank = cmd_bank;
            cap_row = cmd_row; cap_col = cmd_col; cap_code = cmd_code;
        end
        if (cmd_code == 3'd7) obs_pre = t;
        if (cmd_code == 3'd1 && obs_pre >= 0) obs_gap = t - obs_pre;
        req_valid = v; req_op = op; req_addr = addr;
        acc = v && (c != DEPTH);
        if (acc) model_accept(op, addr, t);
        @(posedge clk);
        @(negedge clk);
        t++;
        if (t >= NCYC - 400) begin
            $display("FAIL cycle_budget cycle %0d: got %0d expected below %0d", t, t, NCYC - 400);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    task automatic drain();
        bit a;
        while (t <= end_cyc + 2) step(1'b0, 2'd0, '0, a);
    endtask

    task automatic do_reset(input bit chk_mid);
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (chk_mid) begin
            chk("rst_mid_cmd_valid", cmd_valid, 0);
            chk("rst_mid_cmd_code", cmd_code, 0);
            chk("rst_mid_q_count", q_count, 0);
            chk("rst_mid_q_empty", q_empty, 1);
        end
        rst = 1'b0;
        model_clear();
        t = 0;
    endtask

    initial begin
        vec_t vt [6];
        bit a;
        int pushed, guard;
        logic [63:0] rnd;
        vt[0] = '{2'd0, 34'h0_000C_5680, 0, 5, 1, 3, 5, 3};
        vt[1] = '{2'd1, 34'h0_000C_5680, 0, 5, 1, 3, 5, 5};
        vt[2] = '{2'd2, 34'h0_000C_5680, 0, 5, 1, 3, 5, 3};
        vt[3] = '{2'd0, 34'h3_FFFF_FFFF, 1, 7, 3, 65535, 63, 3};
        vt[4] = '{2'd1, 34'h0_0000_0040, 1, 0, 0, 0, 0, 5};
        vt[5] = '{2'd1, 34'h2_4002_A980, 0, 3, 2, 36864, 42, 5};

        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset(1'b0);
        chk("reset_cmd_ch", cmd_ch, 0);
        chk("reset_cmd_bg", cmd_bg, 0);
        chk("reset_cmd_bank", cmd_bank, 0);
        chk("reset_cmd_row", cmd_row, 0);
        chk("reset_cmd_col", cmd_col, 0);

        // single requests in isolation: decode and CAS code against hand-derived values
        for (int i = 0; i < 6; i++) begin
            cap_code = -1;
            step(1'b1, vt[i].op, vt[i].addr, a);
            chk("tbl_accept", a, 1);
            drain();
            chk("tbl_cas_code", cap_code, vt[i].cas);
            chk("tbl_ch", cap_ch, vt[i].ch);
            chk("tbl_bg", cap_bg, vt[i].bg);
            chk("tbl_bank", cap_bank, vt[i].bank);
            chk("tbl_row", cap_row, vt[i].row);
            chk("tbl_col", cap_col, vt[i].col);
        end

        // write followed immediately by ifetch: ACT0 of the second lands T_RP after PRE
        obs_pre = -1; obs_gap = -1;
        step(1'b1, 2'd1, 34'h0_000C_5680, a);
        step(1'b1, 2'd2, 34'h0_000C_5680, a);
        drain();
        chk("pre_to_act0_gap", obs_gap, T_RP);
        chk("ifetch_cas_code", cap_code, 3);

        // 20 handshaked reads against a busy scheduler
        max_cnt = 0; pushed = 0; guard = 0;
        while (pushed < 20 && guard < 1000) begin
            step(1'b1, 2'd0, ADDR_W'(pushed) << 12 | ADDR_W'(pushed) << 18, a);
            if (a) pushed++;
            guard++;
        end
        chk("fill_pushed", pushed, 20);
        chk("fill_max_q_count", max_cnt, DEPTH);
        drain();

        // illegal op: accepted, one err pulse, nothing queued
        err_pulses = 0;
        step(1'b1, 2'd3, 34'h0_0001_2340, a);
        chk("illegal_accept", a, 1);
        drain();
        chk("illegal_err_pulses", err_pulses, 1);

        // reset while the first of six requests waits in the RCD window
        for (int k = 0; k < 6; k++) step(1'b1, 2'd0, ADDR_W'(k + 1) << 18, a);
        chk("rst_pre_q_count", q_count, 5);
        chk("rst_pre_cmd_valid", cmd_valid, 0);
        do_reset(1'b1);
        for (int k = 0; k < 40; k++) step(1'b0, 2'd0, '0, a);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            rnd = {$urandom, $urandom};
            step(($urandom % 100) < 45, 2'($urandom % 4), rnd[ADDR_W-1:0], a);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
